// File: rtl/rv32i_types_pkg.sv
// Shared RV32 execute-stage types: decoded ALU ops plus the mul/div unit state.
package rv32i_types;

    typedef enum logic [3:0] {
        alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and,
        alu_mul, alu_mulh, alu_mulhsu, alu_mulhu, alu_div, alu_divu, alu_rem, alu_remu
    } alu_ops_t;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, DONE} muldiv_state_t;

    localparam int MULDIV_DIV_ITERS = 32;

    function automatic logic is_mext(alu_ops_t op);
        return op inside {alu_mul, alu_mulh, alu_mulhsu, alu_mulhu,
                          alu_div, alu_divu, alu_rem, alu_remu};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One radix-2 restoring divide iteration: shift in the next dividend bit,
// trial-subtract the divisor, shift the quotient bit into the dividend register.
module div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_dvd,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_dvd
);

    logic [32:0] w_sh;
    logic [33:0] w_diff;
    logic        w_q;

    assign w_sh   = {i_rem, i_dvd[31]};
    assign w_diff = {1'b0, w_sh} - {2'b00, i_divisor};
    assign w_q    = ~w_diff[33];
    assign o_rem  = w_q ? w_diff[31:0] : w_sh[31:0];
    assign o_dvd  = {i_dvd[30:0], w_q};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/done handshake.
// Optional MULDIV_DIV_EARLY_OUT_EN: divide by zero skips the iteration loop.
module muldiv_unit
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  alu_ops_t    aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    muldiv_state_t r_state, w_next;
    alu_ops_t      r_op;
    logic [31:0]   r_a, r_b, r_rem, r_dvd, r_dvsr, r_result;
    logic [4:0]    r_cnt;
    logic          r_sa, r_sb;

    logic          w_start_ok, w_is_div, w_sgn, w_early;
    logic [31:0]   w_abs_a, w_abs_b, w_rem_nx, w_dvd_nx;
    logic [63:0]   w_ma, w_mb, w_prod;
    logic [31:0]   w_mul_res, w_q, w_r, w_fin_res;

    assign w_start_ok = start && is_mext(aluop) && (r_state == IDLE || r_state == DONE);
    assign w_is_div   = aluop inside {alu_div, alu_divu, alu_rem, alu_remu};
    assign w_sgn      = (aluop == alu_div) || (aluop == alu_rem);
    assign w_abs_a    = (w_sgn && a[31]) ? -a : a;
    assign w_abs_b    = (w_sgn && b[31]) ? -b : b;

`ifdef MULDIV_DIV_EARLY_OUT_EN
    assign w_early = (b == 32'd0);
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_ok)
                    w_next = w_is_div ? (w_early ? FIN : DIV) : MUL;
                else if (r_state == DONE)
                    w_next = IDLE;
            end
            MUL:     w_next = DONE;
            DIV:     if (r_cnt == 5'(MULDIV_DIV_ITERS - 1)) w_next = FIN;
            FIN:     w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // 33-bit operands extended to 64 bits; the low 64 bits of the product are exact.
    assign w_ma      = {{32{(r_op == alu_mulh || r_op == alu_mulhsu) && r_a[31]}}, r_a};
    assign w_mb      = {{32{(r_op == alu_mulh) && r_b[31]}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_op == alu_mul) ? w_prod[31:0] : w_prod[63:32];

    div_step u_div_step (
        .i_rem     (r_rem),
        .i_dvd     (r_dvd),
        .i_divisor (r_dvsr),
        .o_rem     (w_rem_nx),
        .o_dvd     (w_dvd_nx)
    );

    always_comb begin
        w_q = r_dvd;
        w_r = r_rem;
        if (r_dvsr == 32'd0) begin
            w_q = 32'hFFFF_FFFF;
            w_r = r_a;
        end else begin
            if (r_sa ^ r_sb) w_q = -r_dvd;
            if (r_sa)        w_r = -r_rem;
        end
        w_fin_res = (r_op == alu_rem || r_op == alu_remu) ? w_r : w_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= alu_add;
            r_a      <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dvd    <= '0;
            r_dvsr   <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_start_ok && !flush) begin
                r_op   <= aluop;
                r_a    <= a;
                r_b    <= b;
                r_sa   <= w_sgn & a[31];
                r_sb   <= w_sgn & b[31];
                r_dvd  <= w_abs_a;
                r_dvsr <= w_abs_b;
                r_rem  <= '0;
                r_cnt  <= '0;
            end else if (r_state == DIV) begin
                r_rem <= w_rem_nx;
                r_dvd <= w_dvd_nx;
                r_cnt <= r_cnt + 5'd1;
            end
            if (!flush && r_state == MUL) r_result <= w_mul_res;
            if (!flush && r_state == FIN) r_result <= w_fin_res;
        end
    end

    assign busy   = (r_state == MUL) || (r_state == DIV) || (r_state == FIN);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule
